// File: rtl/alu_cmd_sequencer.sv
// Command FIFO in front of a registered ALU: issues one command at a time and
// returns tagged results in acceptance order over a valid/ready response port.
module alu_cmd_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_a,
   input  logic [3:0]       cmd_b,
   input  logic [2:0]       cmd_op,
   output logic [3:0]       alu_a,
   output logic [3:0]       alu_b,
   output logic [2:0]       alu_op,
   input  logic [7:0]       alu_c,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [7:0]       rsp_data,
   output logic             rsp_err,
   output logic [1:0]       rsp_tag,
   output logic [CNT_W-1:0] level,
   output logic             busy
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [CNT_W-1:0] DEPTH_L = CNT_W'(FIFO_DEPTH);
   localparam logic [2:0] OP_DIV = 3'd3;

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] op;
      logic [1:0] tag;
   } cmd_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      CAPTURE,
      RESP
   } state_t;

   cmd_t             mem [FIFO_DEPTH];
   cmd_t             head;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [1:0]       accept_cnt;
   logic [1:0]       held_tag;
   logic             held_div0;
   state_t           state;
   logic             push;
   logic             pop;

   // Ready looks only at the stored level, so a full buffer refuses a command
   // even in a cycle where the FSM pops.
   assign cmd_ready = (level < DEPTH_L);
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state == IDLE) && (level != '0);
   assign head      = mem[rd_ptr];

   // NOTE: the storage array has no reset; pointers and level define what is
   // valid, so stale entries are never observed and the array stays plain RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, op: cmd_op, tag: accept_cnt};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         accept_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr     <= wr_ptr + PTR_W'(1);
            accept_cnt <= accept_cnt + 2'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            level <= level + CNT_W'(1);
         end else if (pop && !push) begin
            level <= level - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= '0;
         held_tag  <= '0;
         held_div0 <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         rsp_tag   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pop) begin
                  alu_a     <= head.a;
                  alu_b     <= head.b;
                  alu_op    <= head.op;
                  held_tag  <= head.tag;
                  held_div0 <= (head.op == OP_DIV) && (head.b == 4'd0);
                  state     <= ISSUE;
                  busy      <= 1'b1;
               end
            end
            // The ALU samples alu_* at the edge that closes this state.
            ISSUE: begin
               state <= CAPTURE;
            end
            CAPTURE: begin
               rsp_data  <= held_div0 ? 8'h00 : alu_c;
               rsp_err   <= held_div0;
               rsp_tag   <= held_tag;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural registered ALU on
// the alu_* / alu_c side; expected results are hand-computed constants.
module tb_alu_cmd_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_a;
   logic [3:0] cmd_b;
   logic [2:0] cmd_op;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [2:0] alu_op;
   logic [7:0] alu_c;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic       rsp_err;
   logic [1:0] rsp_tag;
   logic [2:0] level;
   logic       busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_cmd_sequencer #(.FIFO_DEPTH(4), .CNT_W(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .cmd_op    (cmd_op),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_c     (alu_c),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .rsp_tag   (rsp_tag),
      .level     (level),
      .busy      (busy)
   );

   // Downstream registered ALU; divide by zero yields 8'hFF so the sequencer
   // override to 8'h00 is observable.
   always @(posedge clk) begin
      case (alu_op)
         3'd0: alu_c <= {4'd0, alu_a} + {4'd0, alu_b};
         3'd1: alu_c <= {4'd0, alu_a} - {4'd0, alu_b};
         3'd2: alu_c <= alu_a * alu_b;
         3'd3: alu_c <= (alu_b == 4'd0) ? 8'hFF : {4'd0, alu_a / alu_b};
         3'd4: alu_c <= {4'd0, alu_a & alu_b};
         3'd5: alu_c <= {4'd0, alu_a | alu_b};
         3'd6: alu_c <= {4'd0, alu_a ^ alu_b};
         default: alu_c <= {4'd0, ~alu_a};
      endcase
   end

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] op;
      logic [7:0] data;
      logic       err;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One command into an idle, empty sequencer with rsp_ready high.
   task automatic run_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                          input logic [7:0] data, input logic err, input logic [1:0] tag);
      int n;
      cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
      check("cmd_ready_idle", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      tick();
      check("alu_a", alu_a, a);
      check("alu_b", alu_b, b);
      check("alu_op", alu_op, op);
      check("busy_issue", busy, 1);
      n = 1;
      while (!rsp_valid && n < 12) begin
         tick();
         n++;
      end
      check("latency", n, 3);
      check("rsp_data", rsp_data, data);
      check("rsp_err", rsp_err, err);
      check("rsp_tag", rsp_tag, tag);
      tick();
      check("rsp_valid_clear", rsp_valid, 0);
   endtask

   initial begin
      int accepted;
      int got;
      int seen;
      logic ready_before;

      vecs[0]  = '{4'd5,  4'd3,  3'd0, 8'd8,   1'b0};
      vecs[1]  = '{4'd9,  4'd0,  3'd3, 8'd0,   1'b1};
      vecs[2]  = '{4'd9,  4'd2,  3'd3, 8'd4,   1'b0};
      vecs[3]  = '{4'd12, 4'd10, 3'd0, 8'd22,  1'b0};
      vecs[4]  = '{4'd12, 4'd10, 3'd1, 8'd2,   1'b0};
      vecs[5]  = '{4'd12, 4'd10, 3'd2, 8'd120, 1'b0};
      vecs[6]  = '{4'd12, 4'd10, 3'd3, 8'd1,   1'b0};
      vecs[7]  = '{4'd12, 4'd10, 3'd4, 8'd8,   1'b0};
      vecs[8]  = '{4'd12, 4'd10, 3'd5, 8'd14,  1'b0};
      vecs[9]  = '{4'd12, 4'd10, 3'd6, 8'd6,   1'b0};
      vecs[10] = '{4'd12, 4'd10, 3'd7, 8'd3,   1'b0};

      reset = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b1;
      #2;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_tag", rsp_tag, 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_level", level, 0);
      check("rst_busy", busy, 0);
      check("rst_cmd_ready", cmd_ready, 1);
      tick();
      tick();
      reset = 1'b0;

      // Single commands: add, divide by zero, divide, full opcode sweep.
      for (int i = 0; i < 11; i++) begin
         run_cmd(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].data, vecs[i].err, 2'(i % 4));
      end

      // Backpressure: fill the buffer while the first response is stalled.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      rsp_ready = 1'b0;
      accepted = 0;
      for (int i = 0; i < 6; i++) begin
         cmd_a = 4'(accepted + 1); cmd_b = 4'd2; cmd_op = 3'd0; cmd_valid = 1'b1;
         ready_before = cmd_ready;
         tick();
         if (ready_before) accepted++;
      end
      cmd_valid = 1'b0;
      check("full_accepted", accepted, 5);
      check("full_level", level, 4);
      check("full_cmd_ready", cmd_ready, 0);
      check("bp_first_valid", rsp_valid, 1);
      check("bp_tag_0", rsp_tag, 0);
      check("bp_data_0", rsp_data, 3);
      rsp_ready = 1'b1;
      got = 1;
      for (int c = 0; c < 40 && got < 5; c++) begin
         tick();
         if (rsp_valid) begin
            check("bp_tag", rsp_tag, got % 4);
            check("bp_data", rsp_data, got + 3);
            got++;
         end
      end
      check("bp_count", got, 5);
      tick();
      check("bp_level_empty", level, 0);
      check("bp_busy_idle", busy, 0);

      // Hold stability under a long stall.
      rsp_ready = 1'b0;
      cmd_a = 4'd15; cmd_b = 4'd15; cmd_op = 3'd2; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      for (int c = 0; c < 12 && !rsp_valid; c++) tick();
      check("hold_valid_rise", rsp_valid, 1);
      for (int c = 0; c < 10; c++) begin
         tick();
         check("hold_valid", rsp_valid, 1);
         check("hold_data", rsp_data, 225);
         check("hold_tag", rsp_tag, 1);
      end
      rsp_ready = 1'b1;
      tick();
      check("hold_release", rsp_valid, 0);

      // Reset while in CAPTURE with commands still buffered.
      for (int i = 0; i < 3; i++) begin
         cmd_a = 4'(i + 1); cmd_b = 4'(i + 1); cmd_op = 3'd0; cmd_valid = 1'b1;
         tick();
      end
      cmd_valid = 1'b0;
      check("pre_rst_busy", busy, 1);
      check("pre_rst_level", level, 2);
      #3;
      reset = 1'b1;
      #1;
      check("async_rsp_data", rsp_data, 0);
      check("async_rsp_tag", rsp_tag, 0);
      check("async_alu_a", alu_a, 0);
      check("async_level", level, 0);
      check("async_busy", busy, 0);
      check("async_cmd_ready", cmd_ready, 1);
      tick();
      tick();
      reset = 1'b0;
      seen = 0;
      for (int c = 0; c < 15; c++) begin
         tick();
         if (rsp_valid) seen++;
      end
      check("no_stale_rsp", seen, 0);
      run_cmd(4'd7, 4'd1, 3'd1, 8'd6, 1'b0, 2'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
